// File: rtl/random_shuffler.sv
// -----------------------------------------------------------------------------
// random_shuffler
//
// Door-lock keypad scrambler. Holds a 10-entry permutation of the digits 0..9
// and reshuffles it on request with a Fisher-Yates pass whose random indices
// come from a 32-bit XorShift generator seeded from the entropy source.
//
// A shuffle makes one swap per clock, working down from position 9 to 1, so a
// complete pass takes 9 cycles. A new request starts the pass again from
// whatever order the table holds at that moment. Because the table only ever
// changes by swapping two entries, it is a permutation of 0..9 at all times,
// including part-way through a shuffle.
//
// Ports
//   clk           in   1   clock; all state updates on the rising edge
//   rst           in   1   asynchronous, active-high reset
//   shuffle_init  in   1   start or restart a shuffle from seed (level, sampled)
//   seed          in  32   shuffle seed, used only when shuffle_init is sampled
//   limit         in   4   keypad position to read (valid 0..9)
//   prn4          out  4   digit at position limit; 4'hF when limit > 9
// -----------------------------------------------------------------------------
module random_shuffler #(
   // XorShift locks up at zero, so a zero seed is replaced by this value.
   parameter logic [31:0] ZERO_SEED_SUB = 32'h2545_F491
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        shuffle_init,
   input  logic [31:0] seed,
   input  logic [3:0]  limit,
   output logic [3:0]  prn4
);

   localparam int unsigned N_POS = 10;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_SHUF = 1'b1;

   logic [3:0]  r_table [N_POS];
   logic [31:0] r_x;
   logic [3:0]  r_i;
   logic [0:0]  r_state;

   logic [31:0] w_x1;
   logic [31:0] w_x2;
   logic [31:0] w_xn;
   logic [4:0]  w_div;
   logic [3:0]  w_j;
   logic [3:0]  w_ti;
   logic [3:0]  w_tj;
   logic [3:0]  w_prn;
   logic [31:0] w_seed_eff;

   // One XorShift32 step from the current state.
   assign w_x1 = r_x  ^ (r_x  << 13);
   assign w_x2 = w_x1 ^ (w_x1 >> 17);
   assign w_xn = w_x2 ^ (w_x2 << 5);

   assign w_seed_eff = (seed == 32'd0) ? ZERO_SEED_SUB : seed;

   // Divisor i+1 is at most 10, so a 5-bit divisor covers every case.
   assign w_div = {1'b0, r_i} + 5'd1;

   // Remainder xn mod (i+1) by restoring long division, one dividend bit per
   // step, MSB first. The partial remainder stays below the divisor (<= 9),
   // so after shifting in the next bit it fits in 5 bits.
   always_comb begin : mod_blk
      logic [31:0] v_dvd;
      logic [4:0]  v_part;
      logic [3:0]  v_rem;
      // NOTE: loop temporaries here use blocking '=' so each iteration sees the
      // value produced by the previous one; registered state below uses '<='.
      v_dvd  = w_xn;
      v_part = '0;
      v_rem  = '0;
      for (int b = 0; b < 32; b++) begin
         v_part = {v_rem, v_dvd[31]};
         v_dvd  = v_dvd << 1;
         if (v_part >= w_div) begin
            v_part = v_part - w_div;
         end
         v_rem = v_part[3:0];
      end
      w_j = v_rem;
   end

   // Read muxes: the two swap operands and the keypad lookup. Built as
   // compare loops so an out-of-range index simply selects nothing.
   always_comb begin
      // NOTE: every output gets a default before the loops, so no path leaves
      // a value unassigned and no latch is inferred.
      w_ti  = '0;
      w_tj  = '0;
      w_prn = 4'hF;
      for (int k = 0; k < N_POS; k++) begin
         if (r_i == 4'(k)) begin
            w_ti = r_table[k];
         end
         if (w_j == 4'(k)) begin
            w_tj = r_table[k];
         end
         if (limit == 4'(k)) begin
            w_prn = r_table[k];
         end
      end
   end

   assign prn4 = w_prn;

   // Control and datapath. A sampled shuffle_init always wins: it reloads the
   // generator and index without swapping, whether idle or mid-shuffle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: the table is reset entry by entry on purpose; the keypad must
         // show the identity mapping straight out of reset, so it is built from
         // flops rather than a RAM.
         for (int k = 0; k < N_POS; k++) begin
            r_table[k] <= 4'(k);
         end
         r_x     <= ZERO_SEED_SUB;
         r_i     <= 4'd9;
         r_state <= ST_IDLE;
      end else if (shuffle_init) begin
         r_x     <= w_seed_eff;
         r_i     <= 4'd9;
         r_state <= ST_SHUF;
      end else if (r_state == ST_SHUF) begin
         // Swap table[i] and table[j]; when j == i both writes carry the same
         // value, so the entry is left unchanged.
         for (int k = 0; k < N_POS; k++) begin
            if (r_i == 4'(k)) begin
               r_table[k] <= w_tj;
            end else if (w_j == 4'(k)) begin
               r_table[k] <= w_ti;
            end
         end
         r_x <= w_xn;
         r_i <= r_i - 4'd1;
         if (r_i == 4'd1) begin
            r_state <= ST_IDLE;
         end
      end
   end

endmodule

// File: tb/tb_random_shuffler.sv
// -----------------------------------------------------------------------------
// tb_random_shuffler
//
// Self-checking bench for random_shuffler. A reference Fisher-Yates/XorShift32
// model computes the expected table for each shuffle request; the expected
// digits are queued when the request is driven and popped as prn4 is read.
// -----------------------------------------------------------------------------
module tb_random_shuffler;

   localparam logic [31:0] ZERO_SEED_SUB = 32'h2545_F491;

   typedef logic [3:0] tab_t [10];

   logic        clk;
   logic        rst;
   logic        shuffle_init;
   logic [31:0] seed;
   logic [3:0]  limit;
   logic [3:0]  prn4;

   int n_pass;
   int n_total;

   logic [3:0] q_exp [$];
   tab_t       m_tab;

   random_shuffler #(.ZERO_SEED_SUB(ZERO_SEED_SUB)) dut (
      .clk          (clk),
      .rst          (rst),
      .shuffle_init (shuffle_init),
      .seed         (seed),
      .limit        (limit),
      .prn4         (prn4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Watchdog: the bench must never hang.
   initial begin
      #200000;
      $display("FAIL watchdog: timeout reached, got no finish, need finish");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model: n Fisher-Yates steps from table tin with the given seed.
   task automatic model_run(input tab_t tin, input logic [31:0] s, input int n,
                            output tab_t tout);
      logic [31:0] x;
      logic [3:0]  tmp;
      int          i;
      int          j;
      tout = tin;
      x = (s == 32'd0) ? ZERO_SEED_SUB : s;
      for (int step = 0; step < n; step++) begin
         i = 9 - step;
         x = x ^ (x << 13);
         x = x ^ (x >> 17);
         x = x ^ (x << 5);
         j = int'(x % (i + 1));
         tmp     = tout[i];
         tout[i] = tout[j];
         tout[j] = tmp;
      end
   endtask

   task automatic push_table(input tab_t t);
      for (int k = 0; k < 10; k++) q_exp.push_back(t[k]);
   endtask

   function automatic tab_t identity();
      tab_t t;
      for (int k = 0; k < 10; k++) t[k] = 4'(k);
      return t;
   endfunction

   // Read positions 0..9, compare each against the queue, then confirm the
   // observed digits form a permutation. Only used while the table is stable.
   task automatic sweep_check(input string tag);
      logic [15:0] seen;
      logic [3:0]  e;
      seen = '0;
      for (int k = 0; k < 10; k++) begin
         limit = 4'(k);
         #1;
         if (q_exp.size() == 0) begin
            check({tag, " queue_empty"}, 32'd0, 32'd1);
         end else begin
            e = q_exp.pop_front();
            check($sformatf("%s pos%0d", tag, k), 32'(prn4), 32'(e));
         end
         seen[prn4] = 1'b1;
      end
      check({tag, " distinct"}, 32'(seen), 32'h0000_03FF);
   endtask

   // Single-cycle request sampled at the next posedge (E0); returns after E9.
   task automatic shuffle_once(input logic [31:0] s);
      tab_t t;
      @(negedge clk);
      shuffle_init = 1'b1;
      seed         = s;
      @(negedge clk);
      shuffle_init = 1'b0;
      seed         = 32'hDEAD_BEEF;   // must be ignored from here on
      repeat (9) @(negedge clk);
      model_run(m_tab, s, 9, t);
      m_tab = t;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      m_tab = identity();
   endtask

   initial begin
      tab_t t_a;
      tab_t t_b;
      n_pass       = 0;
      n_total      = 0;
      rst          = 1'b1;
      shuffle_init = 1'b0;
      seed         = '0;
      limit        = '0;
      m_tab        = identity();

      // 1. Reset state and out-of-range read.
      do_reset();
      push_table(m_tab);
      sweep_check("reset");
      limit = 4'd12;
      #1;
      check("limit12", 32'(prn4), 32'hF);
      limit = 4'd15;
      #1;
      check("limit15", 32'(prn4), 32'hF);

      // 2. Seed 1 from identity.
      shuffle_once(32'h0000_0001);
      push_table(m_tab);
      sweep_check("seed1");

      // 3. Seed 0 must behave exactly as the substitute seed.
      do_reset();
      shuffle_once(32'h0000_0000);
      push_table(m_tab);
      sweep_check("seed0");
      do_reset();
      shuffle_once(ZERO_SEED_SUB);
      push_table(m_tab);
      sweep_check("seedsub");

      // Continue from a non-identity table with another seed.
      shuffle_once(32'hCAFE_F00D);
      push_table(m_tab);
      sweep_check("chained");

      // 4. Restart mid-shuffle: three swaps from seed A, then the request
      // with seed B is sampled at E4 and a full pass follows.
      @(negedge clk);
      shuffle_init = 1'b1;
      seed         = 32'h1234_5678;
      @(negedge clk);                 // E0 sampled
      shuffle_init = 1'b0;
      @(negedge clk);                 // swap at E1
      @(negedge clk);                 // swap at E2
      @(negedge clk);                 // swap at E3
      shuffle_init = 1'b1;
      seed         = 32'h8765_4321;
      @(negedge clk);                 // restart at E4
      shuffle_init = 1'b0;
      repeat (9) @(negedge clk);
      model_run(m_tab, 32'h1234_5678, 3, t_a);
      model_run(t_a, 32'h8765_4321, 9, t_b);
      m_tab = t_b;
      push_table(m_tab);
      sweep_check("restart");

      // Request held high for several edges: each edge restarts, no swaps
      // until it drops.
      @(negedge clk);
      shuffle_init = 1'b1;
      seed         = 32'h0BAD_F00D;
      repeat (5) @(negedge clk);
      shuffle_init = 1'b0;
      repeat (9) @(negedge clk);
      model_run(m_tab, 32'h0BAD_F00D, 9, t_a);
      m_tab = t_a;
      push_table(m_tab);
      sweep_check("held");

      // 6. limit cycles every clock during and after a shuffle; prn4 must
      // follow the table after each swap. At the c-th negedge after E0,
      // c swaps have been made (capped at 9).
      @(negedge clk);
      shuffle_init = 1'b1;
      seed         = 32'h5A5A_A5A5;
      @(negedge clk);
      shuffle_init = 1'b0;
      for (int c = 0; c < 13; c++) begin
         model_run(m_tab, 32'h5A5A_A5A5, (c < 9) ? c : 9, t_a);
         q_exp.push_back(t_a[c % 10]);
      end
      for (int c = 0; c < 13; c++) begin
         limit = 4'(c % 10);
         #1;
         check($sformatf("track c%0d", c), 32'(prn4), 32'(q_exp.pop_front()));
         check($sformatf("range c%0d", c), 32'(prn4 <= 4'd9), 32'd1);
         @(negedge clk);
      end
      model_run(m_tab, 32'h5A5A_A5A5, 9, t_a);
      m_tab = t_a;

      // 5. Asynchronous reset mid-shuffle, applied away from any edge.
      @(negedge clk);
      shuffle_init = 1'b1;
      seed         = 32'h7777_1111;
      @(negedge clk);
      shuffle_init = 1'b0;
      repeat (3) @(negedge clk);
      limit = 4'd9;
      #2;
      rst = 1'b1;
      #1;
      check("async_rst pos9", 32'(prn4), 32'd9);
      m_tab = identity();
      push_table(m_tab);
      sweep_check("in_rst");
      @(negedge clk);
      rst = 1'b0;
      // Shuffle must have been aborted: table stays identity.
      repeat (10) @(negedge clk);
      push_table(m_tab);
      sweep_check("after_rst");

      check("queue_drained", 32'(q_exp.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
